// File: rtl/constants_pkg.sv
// Shared datapath constants and mux select encodings for the ALU datapath.
package constants_pkg;

   localparam int unsigned REGISTER_DATA_BITS = 8;

   typedef enum logic {
      REGISTER_FILE = 1'b0,
      IMMEDIATE     = 1'b1
   } b_sel_e;

   typedef enum logic [1:0] {
      ALU_OUTPUT     = 2'd0,
      INST_IMMEDIATE = 2'd1,
      MEM_LOAD       = 2'd2,
      REG_FILE_RD0   = 2'd3
   } out_sel_e;

endpackage : constants_pkg

// File: rtl/alu.sv
// Adder/subtractor with carry-out and zero detect; cin doubles as the subtract control.
// Optional signed overflow output when ALU_OVERFLOW_EN is defined.
module alu
   import constants_pkg::*;
#(
   parameter int unsigned WIDTH = REGISTER_DATA_BITS
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ALU_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;

   // Subtract is A + ~B + 1; cout=1 then means no borrow.
   always_comb begin
      b_eff = cin ? ~b : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(cin);
   end

   assign result = sum[WIDTH-1:0];
   assign cout   = sum[WIDTH];
   assign zero   = (sum[WIDTH-1:0] == '0);

`ifdef ALU_OVERFLOW_EN
   // Operands of equal sign producing a result of the other sign.
   assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`endif

endmodule : alu

// File: rtl/alu_datapath.sv
// ALU datapath: operand-B mux, adder, write-back mux and registered flags.
// Define ALU_OVERFLOW_EN to add the ovf / ovf_flag signed-overflow outputs.
module alu_datapath
   import constants_pkg::*;
#(
   parameter int unsigned DATA_BITS = REGISTER_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] rd0_data,
   input  logic [DATA_BITS-1:0] rd1_data,
   input  logic [DATA_BITS-1:0] immediate,
   input  logic [DATA_BITS-1:0] mem_load,
   input  logic                 b_sel,
   input  logic [1:0]           out_sel,
   input  logic                 subtract,
   input  logic                 flags_we,
   output logic [DATA_BITS-1:0] alu_result,
   output logic [DATA_BITS-1:0] out,
   output logic                 cout,
   output logic                 zero,
`ifdef ALU_OVERFLOW_EN
   output logic                 ovf,
   output logic                 ovf_flag,
`endif
   output logic                 carry_flag,
   output logic                 zero_flag
);

   logic [DATA_BITS-1:0] operand_b;
   logic                 carry_flag_q, carry_flag_d;
   logic                 zero_flag_q,  zero_flag_d;

   // Operand B select.
   always_comb begin
      operand_b = rd1_data;
      if (b_sel_e'(b_sel) == IMMEDIATE) begin
         operand_b = immediate;
      end
   end

   alu #(
      .WIDTH (DATA_BITS)
   ) u_alu (
      .a      (rd0_data),
      .b      (operand_b),
      .cin    (subtract),
`ifdef ALU_OVERFLOW_EN
      .ovf    (ovf),
`endif
      .result (alu_result),
      .cout   (cout),
      .zero   (zero)
   );

   // Write-back select; only the chosen input reaches out.
   always_comb begin
      out = alu_result;
      case (out_sel_e'(out_sel))
         ALU_OUTPUT:     out = alu_result;
         INST_IMMEDIATE: out = immediate;
         MEM_LOAD:       out = mem_load;
         REG_FILE_RD0:   out = rd0_data;
         default:        out = alu_result;
      endcase
   end

   always_comb begin
      carry_flag_d = carry_flag_q;
      zero_flag_d  = zero_flag_q;
      if (flags_we) begin
         carry_flag_d = cout;
         zero_flag_d  = zero;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         carry_flag_q <= 1'b0;
         zero_flag_q  <= 1'b0;
      end else begin
         carry_flag_q <= carry_flag_d;
         zero_flag_q  <= zero_flag_d;
      end
   end

   assign carry_flag = carry_flag_q;
   assign zero_flag  = zero_flag_q;

`ifdef ALU_OVERFLOW_EN
   logic ovf_flag_q, ovf_flag_d;

   always_comb begin
      ovf_flag_d = ovf_flag_q;
      if (flags_we) begin
         ovf_flag_d = ovf;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ovf_flag_q <= 1'b0;
      end else begin
         ovf_flag_q <= ovf_flag_d;
      end
   end

   assign ovf_flag = ovf_flag_q;
`endif

endmodule : alu_datapath

// File: tb/tb_alu_datapath.sv
// Directed self-checking bench for alu_datapath (default 8-bit build, optional overflow).
module tb_alu_datapath;

   localparam int unsigned W = 8;

   logic         clk;
   logic         reset;
   logic [W-1:0] rd0_data, rd1_data, immediate, mem_load;
   logic         b_sel;
   logic [1:0]   out_sel;
   logic         subtract;
   logic         flags_we;
   logic [W-1:0] alu_result, out;
   logic         cout, zero, carry_flag, zero_flag;
`ifdef ALU_OVERFLOW_EN
   logic         ovf, ovf_flag;
`endif

   int n_cmp;
   int n_err;

   alu_datapath #(.DATA_BITS(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .rd0_data   (rd0_data),
      .rd1_data   (rd1_data),
      .immediate  (immediate),
      .mem_load   (mem_load),
      .b_sel      (b_sel),
      .out_sel    (out_sel),
      .subtract   (subtract),
      .flags_we   (flags_we),
      .alu_result (alu_result),
      .out        (out),
      .cout       (cout),
      .zero       (zero),
`ifdef ALU_OVERFLOW_EN
      .ovf        (ovf),
      .ovf_flag   (ovf_flag),
`endif
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; flags_we = 1'b1;
      rd0_data = 8'h05; rd1_data = 8'h03; b_sel = 1'b0; subtract = 1'b0; out_sel = 2'd0;
      tick();
      n_cmp++;
      if (carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags: carry=%b zero=%b expected 0 0", carry_flag, zero_flag);
      end
      // combinational path works while reset is held
      n_cmp++;
      if (out !== 8'h08) begin
         n_err++;
         $display("FAIL reset_comb_out: out=%h expected 08", out);
      end
      reset = 1'b1; flags_we = 1'b0;
   endtask

   task automatic test_add();
      rd0_data = 8'h05; rd1_data = 8'h03; immediate = 8'h77; b_sel = 1'b0;
      subtract = 1'b0; out_sel = 2'd0;
      #1;
      n_cmp++;
      if (out !== 8'h08 || alu_result !== 8'h08 || cout !== 1'b0 || zero !== 1'b0) begin
         n_err++;
         $display("FAIL add_basic: out=%h res=%h cout=%b zero=%b expected 08 08 0 0",
                  out, alu_result, cout, zero);
      end
      rd0_data = 8'h3C; immediate = 8'hAA; b_sel = 1'b1;
      #1;
      n_cmp++;
      if (alu_result !== 8'hE6 || cout !== 1'b0) begin
         n_err++;
         $display("FAIL add_imm: res=%h cout=%b expected E6 0", alu_result, cout);
      end
   endtask

   task automatic test_add_wrap();
      rd0_data = 8'hFF; immediate = 8'h01; rd1_data = 8'h20; b_sel = 1'b1;
      subtract = 1'b0; out_sel = 2'd0;
      #1;
      n_cmp++;
      if (alu_result !== 8'h00 || cout !== 1'b1 || zero !== 1'b1) begin
         n_err++;
         $display("FAIL add_wrap: res=%h cout=%b zero=%b expected 00 1 1", alu_result, cout, zero);
      end
      flags_we = 1'b1;
      tick();
      flags_we = 1'b0;
      n_cmp++;
      if (carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
         n_err++;
         $display("FAIL wrap_flags: carry=%b zero=%b expected 1 1", carry_flag, zero_flag);
      end
   endtask

   task automatic test_flags_hold();
      rd0_data = 8'h05; rd1_data = 8'h03; b_sel = 1'b0; subtract = 1'b0; flags_we = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
         n_err++;
         $display("FAIL flags_hold: carry=%b zero=%b expected 1 1", carry_flag, zero_flag);
      end
      // capture a non-zero, no-carry result
      flags_we = 1'b1;
      tick();
      flags_we = 1'b0;
      n_cmp++;
      if (carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
         n_err++;
         $display("FAIL flags_update: carry=%b zero=%b expected 0 0", carry_flag, zero_flag);
      end
   endtask

   task automatic test_subtract();
      rd0_data = 8'h03; rd1_data = 8'h05; b_sel = 1'b0; subtract = 1'b1; out_sel = 2'd0;
      #1;
      n_cmp++;
      if (alu_result !== 8'hFE || cout !== 1'b0 || zero !== 1'b0) begin
         n_err++;
         $display("FAIL sub_borrow: res=%h cout=%b zero=%b expected FE 0 0", alu_result, cout, zero);
      end
      rd0_data = 8'h05;
      #1;
      n_cmp++;
      if (alu_result !== 8'h00 || cout !== 1'b1 || zero !== 1'b1) begin
         n_err++;
         $display("FAIL sub_equal: res=%h cout=%b zero=%b expected 00 1 1", alu_result, cout, zero);
      end
      rd0_data = 8'h10; rd1_data = 8'h01;
      #1;
      n_cmp++;
      if (alu_result !== 8'h0F || cout !== 1'b1) begin
         n_err++;
         $display("FAIL sub_noborrow: res=%h cout=%b expected 0F 1", alu_result, cout);
      end
      subtract = 1'b0;
   endtask

   task automatic test_out_mux();
      logic [W-1:0] exp_tbl [4];
      immediate = 8'hAA; mem_load = 8'h55; rd0_data = 8'h3C; b_sel = 1'b1; subtract = 1'b0;
      exp_tbl[0] = 8'hE6; exp_tbl[1] = 8'hAA; exp_tbl[2] = 8'h55; exp_tbl[3] = 8'h3C;
      for (int s = 0; s < 4; s++) begin
         out_sel = 2'(s);
         #1;
         n_cmp++;
         if (out !== exp_tbl[s]) begin
            n_err++;
            $display("FAIL out_mux_sel%0d: out=%h expected %h", s, out, exp_tbl[s]);
         end
      end
      // unselected input driven to X must not reach out
      mem_load = 'x;
      out_sel = 2'd1;
      #1;
      n_cmp++;
      if (out !== 8'hAA) begin
         n_err++;
         $display("FAIL out_mux_x_isolation: out=%h expected AA", out);
      end
      mem_load = 8'h55;
      out_sel = 2'd0;
   endtask

   task automatic test_reset_priority();
      rd0_data = 8'hFF; immediate = 8'h01; b_sel = 1'b1; subtract = 1'b0;
      flags_we = 1'b1;
      tick();
      n_cmp++;
      if (carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
         n_err++;
         $display("FAIL prio_setup: carry=%b zero=%b expected 1 1", carry_flag, zero_flag);
      end
      reset = 1'b0;
      tick();
      n_cmp++;
      if (carry_flag !== 1'b0 || zero_flag !== 1'b0) begin
         n_err++;
         $display("FAIL reset_priority: carry=%b zero=%b expected 0 0", carry_flag, zero_flag);
      end
      reset = 1'b1;
      tick();
      n_cmp++;
      if (carry_flag !== 1'b1 || zero_flag !== 1'b1) begin
         n_err++;
         $display("FAIL reset_resume: carry=%b zero=%b expected 1 1", carry_flag, zero_flag);
      end
      flags_we = 1'b0;
   endtask

`ifdef ALU_OVERFLOW_EN
   task automatic test_overflow();
      b_sel = 1'b0; out_sel = 2'd0;
      rd0_data = 8'h7F; rd1_data = 8'h01; subtract = 1'b0;
      #1;
      n_cmp++;
      if (ovf !== 1'b1 || alu_result !== 8'h80) begin
         n_err++;
         $display("FAIL ovf_add: ovf=%b res=%h expected 1 80", ovf, alu_result);
      end
      flags_we = 1'b1;
      tick();
      flags_we = 1'b0;
      n_cmp++;
      if (ovf_flag !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_flag_capture: ovf_flag=%b expected 1", ovf_flag);
      end
      rd0_data = 8'h80; rd1_data = 8'h01; subtract = 1'b1;
      #1;
      n_cmp++;
      if (ovf !== 1'b1 || alu_result !== 8'h7F) begin
         n_err++;
         $display("FAIL ovf_sub: ovf=%b res=%h expected 1 7F", ovf, alu_result);
      end
      rd0_data = 8'h10; rd1_data = 8'h10; subtract = 1'b0;
      #1;
      n_cmp++;
      if (ovf !== 1'b0 || alu_result !== 8'h20) begin
         n_err++;
         $display("FAIL ovf_none: ovf=%b res=%h expected 0 20", ovf, alu_result);
      end
      reset = 1'b0; flags_we = 1'b1;
      tick();
      reset = 1'b1; flags_we = 1'b0;
      n_cmp++;
      if (ovf_flag !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_flag_reset: ovf_flag=%b expected 0", ovf_flag);
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0; flags_we = 1'b0;
      rd0_data = '0; rd1_data = '0; immediate = '0; mem_load = '0;
      b_sel = 1'b0; out_sel = 2'd0; subtract = 1'b0;
      @(negedge clk);
      test_reset();
      test_add();
      test_add_wrap();
      test_flags_hold();
      test_subtract();
      test_out_mux();
      test_reset_priority();
`ifdef ALU_OVERFLOW_EN
      test_overflow();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_alu_datapath

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 Parameter DATA_BITS, default 8, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 rd0_data  input  DATA_BITS  ALU operand A; also out_sel path 3.
REQ-005 rd1_data  input  DATA_BITS  operand B candidate, b_sel=0.
REQ-006 immediate  input  DATA_BITS  operand B candidate, b_sel=1; also out_sel path 1.
REQ-007 mem_load  input  DATA_BITS  out_sel path 2.
REQ-008 b_sel  input  1  0=REGISTER_FILE, 1=IMMEDIATE.
REQ-009 out_sel  input  2  0=ALU_OUTPUT, 1=INST_IMMEDIATE, 2=MEM_LOAD, 3=REG_FILE_RD0.
REQ-010 subtract  input  1  0=add, 1=subtract; also the ALU carry-in.
REQ-011 flags_we  input  1  capture flags on next rising clk.
REQ-012 alu_result  output  DATA_BITS  raw ALU result.
REQ-013 out  output  DATA_BITS  selected write-back value.
REQ-014 cout  output  1  combinational carry out.
REQ-015 zero  output  1  combinational, 1 when alu_result==0.
REQ-016 carry_flag, zero_flag  output  1 each  registered flags.

Function
REQ-017 Operand B SHALL be rd1_data when b_sel=0, immediate when b_sel=1.
REQ-018 {cout, alu_result} SHALL equal A + (subtract ? ~B : B) + subtract, computed at DATA_BITS+1 bits.
REQ-019 Subtract: cout=1 means no borrow (A>=B unsigned); cout=0 means borrow.
REQ-020 Addition SHALL wrap modulo 2^DATA_BITS, with the carry on cout only.
REQ-021 out SHALL be alu_result, immediate, mem_load or rd0_data for out_sel 0..3 respectively.
REQ-022 alu_result, cout, zero and out SHALL be purely combinational with zero-cycle latency, independent of reset.
REQ-023 On a rising clk with reset=1 and flags_we=1: carry_flag<=cout and zero_flag<=zero; with flags_we=0 the flags hold.
REQ-024 No X propagation from unselected mux inputs: unselected inputs SHALL NOT affect out.

Reset
REQ-025 On a rising clk with reset=0: carry_flag=0 and zero_flag=0 (and ovf_flag=0 if present); reset overrides flags_we.
REQ-026 Deasserting reset mid-stream SHALL resume flag capture on the first clk edge with reset=1.

Configuration
REQ-027 Macro ALU_OVERFLOW_EN defined: add output ovf (1, combinational signed two's-complement overflow of the add/sub) and output ovf_flag (1, registered with the other flags under the same flags_we and reset rules).
REQ-028 Macro ALU_OVERFLOW_EN undefined: ovf and ovf_flag ports and their logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-029 Package constants_pkg SHALL hold REGISTER_DATA_BITS=8 and the b_sel enum (REGISTER_FILE, IMMEDIATE).
REQ-030 constants_pkg SHALL also hold the out_sel enum (ALU_OUTPUT, INST_IMMEDIATE, MEM_LOAD, REG_FILE_RD0).
REQ-031 The adder/flag arithmetic SHALL be one sub-module named alu, with ports a, b, cin, result, cout, zero.
REQ-032 Both muxes SHALL be inline in alu_datapath.

Verification
REQ-033 Add: rd0=0x05, rd1=0x03, b_sel=0, subtract=0, out_sel=0 -> out=0x08, cout=0, zero=0.
REQ-034 Add wrap: rd0=0xFF, imm=0x01, b_sel=1, add -> alu_result=0x00, cout=1, zero=1; with flags_we=1 for one clk, carry_flag=1 and zero_flag=1.
REQ-035 Subtract: rd0=0x03, rd1=0x05, subtract=1 -> alu_result=0xFE, cout=0; rd0=rd1=0x05 -> 0x00, cout=1, zero=1.
REQ-036 Out mux: imm=0xAA, mem_load=0x55, rd0=0x3C; out_sel 1/2/3 -> out=0xAA/0x55/0x3C.
REQ-037 Reset priority: flags set to 1, then reset=0 with flags_we=1 for one clk -> carry_flag=0, zero_flag=0.
REQ-038 With ALU_OVERFLOW_EN: 0x7F+0x01 -> ovf=1; 0x80-0x01 -> ovf=1; 0x10+0x10 -> ovf=0.
